// File: rtl/core_biu_lsu_bridge_if.sv
// LSU request/response channel plus data-SRAM port of core_biu_lsu_bridge.
// The slave modport is the bridge's view; master is the surrounding core/memory.
interface core_biu_lsu_bridge_if #(
  parameter int XLEN = 32
);
  logic            lsu_req_valid;
  logic            lsu_req_ready;
  logic [XLEN-1:0] lsu_req_addr;
  logic            lsu_req_wen;
  logic [1:0]      lsu_req_size;
  logic            lsu_req_unsigned;
  logic [XLEN-1:0] lsu_req_wdata;
  logic            lsu_rsp_valid;
  logic            lsu_rsp_ready;
  logic [XLEN-1:0] lsu_rsp_rdata;
  logic            lsu_rsp_err;
  logic            mem_cs;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_wmask;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_gnt;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_size, lsu_req_unsigned,
           lsu_req_wdata, lsu_rsp_ready, mem_gnt, mem_rdata,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
           mem_cs, mem_we, mem_addr, mem_wmask, mem_wdata
  );

  modport master (
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_size, lsu_req_unsigned,
           lsu_req_wdata, lsu_rsp_ready, mem_gnt, mem_rdata,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
           mem_cs, mem_we, mem_addr, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/core_biu_lsu_bridge.sv
// Core LSU to word-organised data SRAM bridge: one outstanding access, byte-lane
// alignment, write masking, load extension and an in-order response FIFO.
module core_biu_lsu_bridge #(
  parameter int XLEN      = 32,
  parameter int RSP_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  core_biu_lsu_bridge_if.slave  bus
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RDATA = 2'd2
  } state_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = off[0];
      2'd2:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      2'd0:    m = 4'b0001 << off;
      2'd1:    m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [XLEN-1:0] lane_data(input logic [1:0] size, input logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] d;
    case (size)
      2'd0:    d = {4{wdata[7:0]}};
      2'd1:    d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word, input logic [1:0] off,
                                                  input logic [1:0] size, input logic uns);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh = word >> {off, 3'b000};
    case (size)
      2'd0:    res = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'd1:    res = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  state_t          state_r;
  logic            ready_r;
  logic            mem_cs_r;
  logic            mem_we_r;
  logic [XLEN-1:0] mem_addr_r;
  logic [3:0]      mem_wmask_r;
  logic [XLEN-1:0] mem_wdata_r;
  logic [1:0]      hold_off_r;
  logic [1:0]      hold_size_r;
  logic            hold_uns_r;

  logic [XLEN-1:0]      fifo_rdata_r [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] fifo_err_r;
  logic [PW-1:0]        rd_ptr_r;
  logic [PW-1:0]        wr_ptr_r;
  logic [CW-1:0]        count_r;
  logic                 rsp_valid_r;
  logic [XLEN-1:0]      rsp_rdata_r;
  logic                 rsp_err_r;

  logic            accept_s;
  logic            misal_s;
  logic            push_s;
  logic [XLEN-1:0] push_rdata_s;
  logic            push_err_s;
  logic            pop_s;
  logic [PW-1:0]   rd_ptr_next_s;
  logic [CW-1:0]   count_next_s;
  logic            room_next_s;
  logic [XLEN-1:0] head_rdata_s;
  logic            head_err_s;

  // Request acceptance and the single FIFO push source for each state.
  always_comb begin
    accept_s     = 1'b0;
    misal_s      = misaligned(bus.lsu_req_size, bus.lsu_req_addr[1:0]);
    push_s       = 1'b0;
    push_rdata_s = {XLEN{1'b0}};
    push_err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        accept_s = bus.lsu_req_valid & ready_r;
        if (accept_s && misal_s) begin
          push_s     = 1'b1;
          push_err_s = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (bus.mem_gnt && mem_we_r) begin
          push_s = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      ST_RDATA: begin
        push_s       = 1'b1;
        push_rdata_s = load_extend(bus.mem_rdata, hold_off_r, hold_size_r, hold_uns_r);
      end
      default: begin
        push_s = 1'b0;
      end
    endcase
  end

  // Next FIFO occupancy and next head entry; a push into the slot that becomes
  // the head this cycle is forwarded so the registered head never lags.
  always_comb begin
    pop_s = rsp_valid_r & bus.lsu_rsp_ready;
    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PW'(1'b1);
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1'b1);
      2'b01:   count_next_s = count_r - CW'(1'b1);
      default: count_next_s = count_r;
    endcase
    room_next_s = (count_next_s < DEPTH_C);
    if (count_next_s == {CW{1'b0}}) begin
      head_rdata_s = {XLEN{1'b0}};
      head_err_s   = 1'b0;
    end else if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
      head_rdata_s = push_rdata_s;
      head_err_s   = push_err_s;
    end else begin
      head_rdata_s = fifo_rdata_r[rd_ptr_next_s];
      head_err_s   = fifo_err_r[rd_ptr_next_s];
    end
  end

  // Control FSM with registered request-ready and memory-port outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r     <= ST_IDLE;
      ready_r     <= 1'b1;
      mem_cs_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {XLEN{1'b0}};
      mem_wmask_r <= 4'b0000;
      mem_wdata_r <= {XLEN{1'b0}};
      hold_off_r  <= 2'b00;
      hold_size_r <= 2'b00;
      hold_uns_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            hold_off_r  <= bus.lsu_req_addr[1:0];
            hold_size_r <= bus.lsu_req_size;
            hold_uns_r  <= bus.lsu_req_unsigned;
            if (misal_s) begin
              ready_r <= room_next_s;
            end else begin
              state_r     <= ST_ISSUE;
              ready_r     <= 1'b0;
              mem_cs_r    <= 1'b1;
              mem_we_r    <= bus.lsu_req_wen;
              mem_addr_r  <= {bus.lsu_req_addr[XLEN-1:2], 2'b00};
              mem_wmask_r <= bus.lsu_req_wen ? lane_mask(bus.lsu_req_size, bus.lsu_req_addr[1:0]) : 4'b0000;
              mem_wdata_r <= bus.lsu_req_wen ? lane_data(bus.lsu_req_size, bus.lsu_req_wdata) : {XLEN{1'b0}};
            end
          end else begin
            ready_r <= room_next_s;
          end
        end
        ST_ISSUE: begin
          if (bus.mem_gnt) begin
            mem_cs_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {XLEN{1'b0}};
            mem_wmask_r <= 4'b0000;
            mem_wdata_r <= {XLEN{1'b0}};
            if (mem_we_r) begin
              state_r <= ST_IDLE;
              ready_r <= room_next_s;
            end else begin
              state_r <= ST_RDATA;
              ready_r <= 1'b0;
            end
          end else begin
            ready_r <= 1'b0;
          end
        end
        ST_RDATA: begin
          state_r <= ST_IDLE;
          ready_r <= room_next_s;
        end
        default: begin
          state_r  <= ST_IDLE;
          ready_r  <= 1'b0;
          mem_cs_r <= 1'b0;
          mem_we_r <= 1'b0;
        end
      endcase
    end
  end

  // Response FIFO storage, pointers and registered head outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_rdata_r[i] <= {XLEN{1'b0}};
      end
      fifo_err_r  <= {RSP_DEPTH{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {XLEN{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_rdata_r[wr_ptr_r] <= push_rdata_s;
        fifo_err_r[wr_ptr_r]   <= push_err_s;
        wr_ptr_r               <= wr_ptr_r + PW'(1'b1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r    <= rd_ptr_next_s;
      count_r     <= count_next_s;
      rsp_valid_r <= (count_next_s != {CW{1'b0}});
      rsp_rdata_r <= head_rdata_s;
      rsp_err_r   <= head_err_s;
    end
  end

  // Ready is held low while reset is applied and rises as soon as it is released.
  assign bus.lsu_req_ready = ready_r & ~rst_n;
  assign bus.lsu_rsp_valid = rsp_valid_r;
  assign bus.lsu_rsp_rdata = rsp_rdata_r;
  assign bus.lsu_rsp_err   = rsp_err_r;
  assign bus.mem_cs        = mem_cs_r;
  assign bus.mem_we        = mem_we_r;
  assign bus.mem_addr      = mem_addr_r;
  assign bus.mem_wmask     = mem_wmask_r;
  assign bus.mem_wdata     = mem_wdata_r;

endmodule

// File: tb/tb_core_biu_lsu_bridge.sv
// Scoreboard bench for core_biu_lsu_bridge: a small SRAM model with controllable
// grant, expected responses queued at request acceptance and compared on pop.
module tb_core_biu_lsu_bridge;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    string       tag;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc = 0;
  int   cs_cnt = 0;
  int   last_acc;
  int   prev_acc;
  int   c0;
  exp_t exp_q[$];
  exp_t e_mon;

  logic [31:0] mem_m [0:255];
  logic [3:0]  last_wmask;
  logic [31:0] last_wdata;
  logic [31:0] last_waddr;

  core_biu_lsu_bridge_if #(.XLEN(32)) bus ();

  core_biu_lsu_bridge #(.XLEN(32), .RSP_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // SRAM model: writes and read capture happen on the granting edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_cs) cs_cnt <= cs_cnt + 1;
    if (bus.mem_cs && bus.mem_gnt) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_wmask[b]) mem_m[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
        last_wmask <= bus.mem_wmask;
        last_wdata <= bus.mem_wdata;
        last_waddr <= bus.mem_addr;
      end else begin
        bus.mem_rdata <= mem_m[bus.mem_addr[9:2]];
      end
    end
  end

  // Response monitor: pops the scoreboard on every accepted response
  always @(negedge clk) begin
    if (!rst && bus.lsu_rsp_valid && bus.lsu_rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e_mon = exp_q.pop_front();
        chk({e_mon.tag, "_rdata"}, bus.lsu_rsp_rdata, e_mon.rdata);
        chk({e_mon.tag, "_err"}, {31'd0, bus.lsu_rsp_err}, {31'd0, e_mon.err});
        if (e_mon.cyc >= 0) chk({e_mon.tag, "_cycle"}, 32'(cyc), 32'(e_mon.cyc));
      end
    end
  end

  task automatic send(input string tag, input logic [31:0] addr, input logic wen, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata, input logic [31:0] er, input logic ee,
                      input int lat);
    int   n;
    exp_t e;
    n = 0;
    bus.lsu_req_valid    = 1'b1;
    bus.lsu_req_addr     = addr;
    bus.lsu_req_wen      = wen;
    bus.lsu_req_size     = size;
    bus.lsu_req_unsigned = uns;
    bus.lsu_req_wdata    = wdata;
    while (bus.lsu_req_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_accept"}, {31'd0, bus.lsu_req_ready}, 32'd1);
    e.rdata  = er;
    e.err    = ee;
    e.tag    = tag;
    e.cyc    = (lat > 0) ? cyc + lat : -1;
    prev_acc = last_acc;
    last_acc = cyc;
    exp_q.push_back(e);
    tick();
    bus.lsu_req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, {31'd0, bus.lsu_req_ready}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, bus.lsu_rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, bus.lsu_rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"}, {31'd0, bus.lsu_rsp_err}, 32'd0);
    chk({tag, "_mem_cs"}, {31'd0, bus.mem_cs}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, bus.mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    chk({tag, "_mem_wmask"}, {28'd0, bus.mem_wmask}, 32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    last_acc = 0;
    prev_acc = 0;
    rst                  = 1'b1;
    bus.lsu_req_valid    = 1'b0;
    bus.lsu_req_addr     = 32'd0;
    bus.lsu_req_wen      = 1'b0;
    bus.lsu_req_size     = 2'd0;
    bus.lsu_req_unsigned = 1'b0;
    bus.lsu_req_wdata    = 32'd0;
    bus.lsu_rsp_ready    = 1'b1;
    bus.mem_gnt          = 1'b1;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    #1;
    chk("post_reset_ready", {31'd0, bus.lsu_req_ready}, 32'd1);

    // word store then load, back to back
    send("st_w100", 32'h100, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    send("ld_w100", 32'h100, 1'b0, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 3);
    chk("store_spacing", 32'(last_acc - prev_acc), 32'd2);
    drain("word");
    chk("st_w_mask", {28'd0, last_wmask}, 32'h0000000F);
    chk("st_w_data", last_wdata, 32'hDEADBEEF);

    // byte/half extension on word 0x80FF7F01
    send("st_ext", 32'h100, 1'b1, 2'd2, 1'b0, 32'h80FF7F01, 32'h0, 1'b0, 2);
    send("ld_bs103", 32'h103, 1'b0, 2'd0, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0, 3);
    send("ld_bu103", 32'h103, 1'b0, 2'd0, 1'b1, 32'h0, 32'h00000080, 1'b0, 3);
    chk("load_spacing", 32'(last_acc - prev_acc), 32'd3);
    send("ld_hs102", 32'h102, 1'b0, 2'd1, 1'b0, 32'h0, 32'hFFFF80FF, 1'b0, 3);
    send("ld_hu100", 32'h100, 1'b0, 2'd1, 1'b1, 32'h0, 32'h00007F01, 1'b0, 3);
    send("ld_bs101", 32'h101, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0000007F, 1'b0, 3);
    drain("ext");

    send("st_b102", 32'h102, 1'b1, 2'd0, 1'b0, 32'h123456AB, 32'h0, 1'b0, 2);
    drain("stb");
    chk("st_b_mask", {28'd0, last_wmask}, 32'h00000004);
    chk("st_b_data", last_wdata, 32'hABABABAB);
    chk("st_b_addr", last_waddr, 32'h00000100);
    send("ld_after_b", 32'h100, 1'b0, 2'd2, 1'b0, 32'h0, 32'h80AB7F01, 1'b0, 3);
    send("st_h102", 32'h102, 1'b1, 2'd1, 1'b0, 32'hCAFE5566, 32'h0, 1'b0, 2);
    drain("sth");
    chk("st_h_mask", {28'd0, last_wmask}, 32'h0000000C);
    chk("st_h_data", last_wdata, 32'h55665566);
    send("ld_hu102", 32'h102, 1'b0, 2'd1, 1'b1, 32'h0, 32'h00005566, 1'b0, 3);
    drain("ldh");

    // misaligned and reserved-size requests never reach memory
    c0 = cs_cnt;
    send("mis_w101", 32'h101, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, 1);
    send("mis_h103", 32'h103, 1'b1, 2'd1, 1'b0, 32'hFFFF, 32'h0, 1'b1, 1);
    chk("mis_spacing", 32'(last_acc - prev_acc), 32'd1);
    send("mis_sz3", 32'h100, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1, 1);
    drain("mis");
    chk("mis_no_cs", 32'(cs_cnt), 32'(c0));

    // grant held low for three cycles
    bus.mem_gnt = 1'b0;
    send("st_stall", 32'h108, 1'b1, 2'd2, 1'b0, 32'h12345678, 32'h0, 1'b0, 5);
    for (int i = 0; i < 3; i++) begin
      chk("stall_cs", {31'd0, bus.mem_cs}, 32'd1);
      chk("stall_addr", bus.mem_addr, 32'h00000108);
      chk("stall_mask", {28'd0, bus.mem_wmask}, 32'h0000000F);
      chk("stall_data", bus.mem_wdata, 32'h12345678);
      chk("stall_ready", {31'd0, bus.lsu_req_ready}, 32'd0);
      tick();
    end
    bus.mem_gnt = 1'b1;
    drain("stall");
    chk("stall_waddr", last_waddr, 32'h00000108);
    send("ld_bu109", 32'h109, 1'b0, 2'd0, 1'b1, 32'h0, 32'h00000056, 1'b0, 3);
    drain("ld109");

    // response backpressure fills the FIFO
    bus.lsu_rsp_ready = 1'b0;
    send("bp_st1", 32'h10C, 1'b1, 2'd2, 1'b0, 32'h11111111, 32'h0, 1'b0, 0);
    send("bp_st2", 32'h110, 1'b1, 2'd2, 1'b0, 32'h22222222, 32'h0, 1'b0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("bp_full_ready", {31'd0, bus.lsu_req_ready}, 32'd0);
      chk("bp_full_valid", {31'd0, bus.lsu_rsp_valid}, 32'd1);
      tick();
    end
    bus.lsu_rsp_ready = 1'b1;
    tick();
    bus.lsu_rsp_ready = 1'b0;
    chk("bp_pop_ready", {31'd0, bus.lsu_req_ready}, 32'd1);
    chk("bp_left", 32'(exp_q.size()), 32'd1);
    bus.lsu_rsp_ready = 1'b1;
    drain("bp");

    // reset while a load sits in RDATA and one response is held
    bus.lsu_rsp_ready = 1'b0;
    send("rst_st", 32'h114, 1'b1, 2'd2, 1'b0, 32'h33333333, 32'h0, 1'b0, 0);
    send("rst_ld", 32'h100, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    tick();
    rst = 1'b1;
    tick();
    chk_all_zero("mid_reset");
    exp_q.delete();
    rst = 1'b0;
    #1;
    chk("mid_reset_ready", {31'd0, bus.lsu_req_ready}, 32'd1);
    bus.lsu_rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    send("ld_final", 32'h100, 1'b0, 2'd2, 1'b0, 32'h0, 32'h55667F01, 1'b0, 3);
    drain("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
